// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, offsets and byte-lane helper for the load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    REG_DMEM,
    REG_OUT,
    REG_SW,
    REG_BTN,
    REG_NONE
  } region_e;

  localparam logic [31:0] SW_OFS     = 32'h0000_0800;
  localparam logic [31:0] BTN_OFS    = 32'h0000_0810;
  localparam logic [31:0] OUT_STRIDE = 32'd16;

  // Byte lanes touched by an access; all-zero marks an illegal width code.
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: lane_mask = 4'b0001 << a;
      F3_H, F3_HU: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      F3_W:        lane_mask = 4'b1111;
      default:     lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// rtl/lsu_dmem.sv - word-wide synchronous RAM with byte write enables and registered read
module lsu_dmem #(
  parameter int WORDS = 2048,
  parameter int AW    = 11
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [WORDS];

  // Byte-masked write and read-before-write registered read on one port.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      o_rdata <= mem[i_addr];
    end
  end

endmodule

// File: rtl/lsu_mmio.sv
// rtl/lsu_mmio.sv - load/store unit with data memory and MMIO window (option: LSU_INPUT_SYNC_EN)
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] IO_BASE    = 32'h0000_7000,
  parameter int          NUM_OUT_CH = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req,
  input  logic                    i_wren,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_lsu_addr,
  input  logic [31:0]             i_st_data,
  input  logic [31:0]             i_io_sw,
  input  logic [3:0]              i_io_btn,
  output logic [31:0]             o_ld_data,
  output logic                    o_rsp_valid,
  output logic                    o_err,
  output logic [32*NUM_OUT_CH-1:0] o_io_out
);

  localparam int          AW         = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);
  localparam logic [27:0] NCH        = 28'(NUM_OUT_CH);
  localparam logic [29:0] IO_BASE_W  = IO_BASE[31:2];

  logic [31:0] sw_in;
  logic [3:0]  btn_in;

`ifdef LSU_INPUT_SYNC_EN
  logic [35:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous board inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {i_io_btn, i_io_sw};
      sync2_q <= sync1_q;
    end
  end

  assign sw_in  = sync2_q[31:0];
  assign btn_in = sync2_q[35:32];
`else
  assign sw_in  = i_io_sw;
  assign btn_in = i_io_btn;
`endif

  // Word offset into the I/O window; only meaningful when the address is at or above IO_BASE.
  logic [29:0] ofs_w;
  logic [3:0]  ch_sel;
  region_e     region;
  assign ofs_w  = i_lsu_addr[31:2] - IO_BASE_W;
  assign ch_sel = ofs_w[5:2];

  // Address decode into one region.
  always_comb begin
    region = REG_NONE;
    if (i_lsu_addr < DMEM_BYTES) begin
      region = REG_DMEM;
    end else if (i_lsu_addr >= IO_BASE) begin
      if (ofs_w == SW_OFS[31:2])                        region = REG_SW;
      else if (ofs_w == BTN_OFS[31:2])                  region = REG_BTN;
      else if (ofs_w[1:0] == 2'b00 && ofs_w[29:2] < NCH) region = REG_OUT;
    end
  end

  logic [3:0]  mask;
  logic        misal, ld_err, st_err, err, wr_ok;
  logic [31:0] wdata;
  assign mask   = lane_mask(i_lsu_addr[1:0], i_funct3);
  assign misal  = (i_funct3[1:0] == 2'b01 && i_lsu_addr[0]) ||
                  (i_funct3[1:0] == 2'b10 && i_lsu_addr[1:0] != 2'b00);
  assign ld_err = (mask == 4'b0000) || misal || (region == REG_NONE);
  assign st_err = ld_err || i_funct3[2] || (region == REG_SW) || (region == REG_BTN);
  assign err    = i_wren ? st_err : ld_err;
  assign wr_ok  = i_req && i_wren && !err;

  // Replicate right-aligned store data across the lanes it may land in.
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   wdata = {4{i_st_data[7:0]}};
      2'b01:   wdata = {2{i_st_data[15:0]}};
      default: wdata = i_st_data;
    endcase
  end

  logic [31:0] ram_rdata;
  lsu_dmem #(.WORDS(DMEM_WORDS), .AW(AW)) u_dmem (
    .i_clk   (i_clk),
    .i_en    (i_req),
    .i_be    ((wr_ok && region == REG_DMEM) ? mask : 4'b0000),
    .i_addr  (i_lsu_addr[AW+1:2]),
    .i_wdata (wdata),
    .o_rdata (ram_rdata)
  );

  for (genvar k = 0; k < NUM_OUT_CH; k++) begin : g_ch
    logic [31:0] ch_q;
    // Output channel register, written lane by lane.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        ch_q <= '0;
      end else if (wr_ok && region == REG_OUT && ch_sel == 4'(k)) begin
        for (int b = 0; b < 4; b++) begin
          if (mask[b]) ch_q[8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    assign o_io_out[32*k +: 32] = ch_q;
  end

  // I/O read word captured in the request cycle, alongside the RAM read.
  logic [31:0] io_rd;
  always_comb begin
    io_rd = '0;
    case (region)
      REG_SW:  io_rd = sw_in;
      REG_BTN: io_rd = {28'b0, btn_in};
      REG_OUT: begin
        for (int k = 0; k < NUM_OUT_CH; k++) begin
          if (ch_sel == 4'(k)) io_rd = o_io_out[32*k +: 32];
        end
      end
      default: io_rd = '0;
    endcase
  end

  logic        rsp_valid_q, err_q, ld_ok_q, from_mem_q;
  logic [31:0] io_word_q;
  logic [1:0]  a_lo_q;
  logic [2:0]  f3_q;

  // Response pipeline register: one response per accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ld_ok_q     <= 1'b0;
      from_mem_q  <= 1'b0;
      io_word_q   <= '0;
      a_lo_q      <= '0;
      f3_q        <= '0;
    end else begin
      rsp_valid_q <= i_req;
      err_q       <= i_req && err;
      ld_ok_q     <= i_req && !i_wren && !err;
      from_mem_q  <= (region == REG_DMEM);
      io_word_q   <= io_rd;
      a_lo_q      <= i_lsu_addr[1:0];
      f3_q        <= i_funct3;
    end
  end

  logic [31:0] word, shifted;

  // Lane extraction and extension of the registered read word.
  always_comb begin
    word      = from_mem_q ? ram_rdata : io_word_q;
    shifted   = word >> {a_lo_q, 3'b000};
    o_ld_data = '0;
    if (ld_ok_q) begin
      case (f3_q)
        F3_B:    o_ld_data = {{24{shifted[7]}}, shifted[7:0]};
        F3_BU:   o_ld_data = {24'b0, shifted[7:0]};
        F3_H:    o_ld_data = {{16{shifted[15]}}, shifted[15:0]};
        F3_HU:   o_ld_data = {16'b0, shifted[15:0]};
        F3_W:    o_ld_data = shifted;
        default: o_ld_data = '0;
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// tb/tb_lsu_mmio.sv - self-checking bench: directed vector table, hand sequences, random vs. model
module tb_lsu_mmio;

  localparam int          DW  = 2048;
  localparam logic [31:0] IOB = 32'h0000_7000;
  localparam int          NCH = 5;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_req = 1'b0;
  logic i_wren = 1'b0;
  logic [2:0] i_funct3 = '0;
  logic [31:0] i_lsu_addr = '0;
  logic [31:0] i_st_data = '0;
  logic [31:0] i_io_sw = '0;
  logic [3:0] i_io_btn = '0;
  logic [31:0] o_ld_data;
  logic o_rsp_valid, o_err;
  logic [32*NCH-1:0] o_io_out;

  lsu_mmio #(.DMEM_WORDS(DW), .IO_BASE(IOB), .NUM_OUT_CH(NCH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wren(i_wren),
    .i_funct3(i_funct3), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
    .i_io_sw(i_io_sw), .i_io_btn(i_io_btn), .o_ld_data(o_ld_data),
    .o_rsp_valid(o_rsp_valid), .o_err(o_err), .o_io_out(o_io_out)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [int];
  logic [31:0] mch [NCH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: byte-addressed view of memory and channels, applied per access.
  task automatic model(input bit req, input bit wren, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output bit ev, output bit ee, output logic [31:0] ed);
    int size, rg, ch;
    logic [31:0] o, w;
    bit bad;
    ev = req; ee = 1'b0; ed = '0;
    if (!req) return;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    rg = 4; ch = 0;
    if (a < DW * 4) rg = 0;
    else if (a >= IOB) begin
      o = a - IOB;
      if (o >= 32'h800 && o < 32'h804)      rg = 2;
      else if (o >= 32'h810 && o < 32'h814) rg = 3;
      else if (o < 16 * NCH && o % 16 < 4) begin rg = 1; ch = int'(o / 16); end
    end
    bad = (size == 0) || (rg == 4) || (size != 0 && (a % size) != 0);
    if (wren) bad = bad || rg == 2 || rg == 3 || f3 > 3'd2;
    if (bad) begin ee = 1'b1; return; end
    if (rg == 0)      w = mm.exists(int'(a / 4)) ? mm[int'(a / 4)] : 32'h0;
    else if (rg == 1) w = mch[ch];
    else if (rg == 2) w = i_io_sw;
    else              w = {28'b0, i_io_btn};
    if (wren) begin
      for (int i = 0; i < size; i++) w[8 * (int'(a % 4) + i) +: 8] = d[8 * i +: 8];
      if (rg == 0) mm[int'(a / 4)] = w; else mch[ch] = w;
    end else begin
      w = w >> (8 * (a % 4));
      if (size == 1)      ed = (f3 == 3'd0) ? {{24{w[7]}}, w[7:0]} : {24'b0, w[7:0]};
      else if (size == 2) ed = (f3 == 3'd1) ? {{16{w[15]}}, w[15:0]} : {16'b0, w[15:0]};
      else                ed = w;
    end
  endtask

  task automatic step(input bit req, input bit wren, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      output bit gv, output bit ge, output logic [31:0] gd,
                      output bit ev, output bit ee, output logic [31:0] ed);
    i_req = req; i_wren = wren; i_funct3 = f3; i_lsu_addr = a; i_st_data = d;
    model(req, wren, f3, a, d, ev, ee, ed);
    @(posedge i_clk); #1;
    gv = o_rsp_valid; ge = o_err; gd = o_ld_data;
  endtask

  task automatic chk_step(input string nm, input bit req, input bit wren, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit xv, input bit xe, input logic [31:0] xd);
    bit gv, ge, ev, ee;
    logic [31:0] gd, ed;
    step(req, wren, f3, a, d, gv, ge, gd, ev, ee, ed);
    chk({nm, ".valid"}, {31'b0, gv}, {31'b0, xv});
    chk({nm, ".err"}, {31'b0, ge}, {31'b0, xe});
    chk({nm, ".data"}, gd, xd);
  endtask

  typedef struct {
    string       nm;
    bit          req;
    bit          wren;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    bit          ev;
    bit          ee;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(string nm, bit req, bit wren, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] d, bit ev, bit ee, logic [31:0] ed);
    vec_t v;
    v.nm = nm; v.req = req; v.wren = wren; v.f3 = f3; v.a = a; v.d = d;
    v.ev = ev; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    bit gv, ge, ev, ee;
    logic [31:0] gd, ed, a, d;
    logic [2:0] f3;
    bit req, wren;

    // Reset state, observed while reset is still asserted.
    #1;
    chk("rst.valid", {31'b0, o_rsp_valid}, 32'h0);
    chk("rst.err", {31'b0, o_err}, 32'h0);
    chk("rst.data", o_ld_data, 32'h0);
    for (int k = 0; k < NCH; k++) chk($sformatf("rst.ch%0d", k), o_io_out[32*k +: 32], 32'h0);
    for (int k = 0; k < NCH; k++) mch[k] = '0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    tbl.push_back(mk("sw_10",    1, 1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0));
    tbl.push_back(mk("lw_10",    1, 0, 3'd2, 32'h10, 32'h0,        1, 0, 32'hDEADBEEF));
    tbl.push_back(mk("sb_11",    1, 1, 3'd0, 32'h11, 32'h00000080, 1, 0, 32'h0));
    tbl.push_back(mk("lb_11",    1, 0, 3'd0, 32'h11, 32'h0,        1, 0, 32'hFFFFFF80));
    tbl.push_back(mk("lbu_11",   1, 0, 3'd4, 32'h11, 32'h0,        1, 0, 32'h00000080));
    tbl.push_back(mk("lw_10b",   1, 0, 3'd2, 32'h10, 32'h0,        1, 0, 32'hDEAD80EF));
    tbl.push_back(mk("sh_13",    1, 1, 3'd1, 32'h13, 32'h1234,     1, 1, 32'h0));
    tbl.push_back(mk("lw_10c",   1, 0, 3'd2, 32'h10, 32'h0,        1, 0, 32'hDEAD80EF));
    tbl.push_back(mk("lw_12",    1, 0, 3'd2, 32'h12, 32'h0,        1, 1, 32'h0));
    tbl.push_back(mk("lh_12",    1, 0, 3'd1, 32'h12, 32'h0,        1, 0, 32'hFFFFDEAD));
    tbl.push_back(mk("lhu_12",   1, 0, 3'd5, 32'h12, 32'h0,        1, 0, 32'h0000DEAD));
    tbl.push_back(mk("idle",     0, 0, 3'd2, 32'h10, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("sw_ch2",   1, 1, 3'd2, IOB + 32'h20, 32'h0003FFFF, 1, 0, 32'h0));
    tbl.push_back(mk("lw_ch2",   1, 0, 3'd2, IOB + 32'h20, 32'h0,  1, 0, 32'h0003FFFF));
    tbl.push_back(mk("sw_ch5",   1, 1, 3'd2, IOB + 32'h50, 32'h12345678, 1, 1, 32'h0));
    tbl.push_back(mk("sb_ch2",   1, 1, 3'd0, IOB + 32'h22, 32'h55,  1, 0, 32'h0));
    tbl.push_back(mk("lw_ch2b",  1, 0, 3'd2, IOB + 32'h20, 32'h0,  1, 0, 32'h0055FFFF));
    tbl.push_back(mk("lw_f3bad", 1, 0, 3'd3, 32'h10, 32'h0,        1, 1, 32'h0));
    tbl.push_back(mk("sbu_bad",  1, 1, 3'd4, 32'h10, 32'h0,        1, 1, 32'h0));
    tbl.push_back(mk("sw_top",   1, 1, 3'd2, 32'h1FFC, 32'h0BADF00D, 1, 0, 32'h0));
    tbl.push_back(mk("lw_top",   1, 0, 3'd2, 32'h1FFC, 32'h0,      1, 0, 32'h0BADF00D));
    tbl.push_back(mk("lb_past",  1, 0, 3'd0, 32'h2000, 32'h0,      1, 1, 32'h0));
    tbl.push_back(mk("lw_hole",  1, 0, 3'd2, IOB + 32'h24, 32'h0,  1, 1, 32'h0));

    foreach (tbl[i]) chk_step(tbl[i].nm, tbl[i].req, tbl[i].wren, tbl[i].f3, tbl[i].a,
                              tbl[i].d, tbl[i].ev, tbl[i].ee, tbl[i].ed);
    chk("ch2_after", o_io_out[64 +: 32], 32'h0055FFFF);
    for (int k = 0; k < NCH; k++) if (k != 2) chk($sformatf("ch%0d_untouched", k), o_io_out[32*k +: 32], 32'h0);

    // Input reads after the inputs settle (long enough for the synchronized build too).
    i_io_sw = 32'hA5A5A5A5; i_io_btn = 4'hA;
    for (int i = 0; i < 3; i++) chk_step("settle", 0, 0, 3'd2, 32'h0, 32'h0, 0, 0, 32'h0);
    chk_step("lw_sw",   1, 0, 3'd2, IOB + 32'h800, 32'h0, 1, 0, 32'hA5A5A5A5);
    chk_step("lh_sw",   1, 0, 3'd1, IOB + 32'h802, 32'h0, 1, 0, 32'hFFFFA5A5);
    chk_step("sw_sw",   1, 1, 3'd2, IOB + 32'h800, 32'h1, 1, 1, 32'h0);
    chk_step("lbu_btn", 1, 0, 3'd4, IOB + 32'h810, 32'h0, 1, 0, 32'h0000000A);
    chk_step("lb_btn",  1, 0, 3'd0, IOB + 32'h810, 32'h0, 1, 0, 32'h0000000A);
    chk_step("sb_btn",  1, 1, 3'd0, IOB + 32'h810, 32'h1, 1, 1, 32'h0);

    // Preload the random DMEM window so every word there has known content.
    for (int i = 0; i < 16; i++) chk_step("preload", 1, 1, 3'd2, 32'(4 * i), $urandom, 1, 0, 32'h0);

    for (int it = 0; it < 400; it++) begin
      req  = ($urandom_range(0, 9) != 0);
      wren = $urandom_range(0, 1);
      f3   = 3'($urandom_range(0, 7));
      d    = $urandom;
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = IOB + 32'(16 * $urandom_range(0, NCH)) + 32'($urandom_range(0, 7));
        3:       a = IOB + 32'h800 + 32'($urandom_range(0, 3));
        4:       a = IOB + 32'h810 + 32'($urandom_range(0, 3));
        default: a = $urandom_range(0, 1) ? 32'h2000 + 32'($urandom_range(0, 255)) : IOB + 32'h900;
      endcase
      step(req, wren, f3, a, d, gv, ge, gd, ev, ee, ed);
      chk($sformatf("rnd%0d.valid", it), {31'b0, gv}, {31'b0, ev});
      chk($sformatf("rnd%0d.err", it), {31'b0, ge}, {31'b0, ee});
      chk($sformatf("rnd%0d.data a=%h f3=%0d", it, a, f3), gd, ed);
      for (int k = 0; k < NCH; k++) chk($sformatf("rnd%0d.ch%0d", it, k), o_io_out[32*k +: 32], mch[k]);
    end

    // Reset asserted in the middle of a request cycle.
    chk_step("sw_ch0", 1, 1, 3'd2, IOB, 32'h000000FF, 1, 0, 32'h0);
    chk("ch0_set", o_io_out[31:0], 32'h000000FF);
    i_req = 1'b1; i_wren = 1'b0; i_funct3 = 3'd2; i_lsu_addr = 32'h10;
    #2;
    i_rst_n = 1'b0;
    #1;
    for (int k = 0; k < NCH; k++) chk($sformatf("midrst.ch%0d", k), o_io_out[32*k +: 32], 32'h0);
    chk("midrst.valid", {31'b0, o_rsp_valid}, 32'h0);
    chk("midrst.err", {31'b0, o_err}, 32'h0);
    chk("midrst.data", o_ld_data, 32'h0);
    i_req = 1'b0;
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("postrst.valid", {31'b0, o_rsp_valid}, 32'h0);
    chk("postrst.ch0", o_io_out[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Parametrised load/store unit for the single-cycle/pipelined RISC-V core: it owns the word-addressed data memory and a memory-mapped I/O window of NUM_OUT_CH output channels and two input channels. It supports byte/halfword/word stores with byte-lane masking, sign- and zero-extended sub-word loads, and misalignment and unmapped-address errors. It sits between the core's execute/memory stage and the board peripherals (LEDs, HEX, LCD, switches, keys).

## Interface
Parameters:
- DMEM_WORDS, 2048, data memory depth in 32-bit words (power of two)
- IO_BASE, 32'h0000_7000, base byte address of the I/O window
- NUM_OUT_CH, 5, number of 32-bit output channels (1..16)

Ports:
- i_clk  in  1  sole clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  access request this cycle
- i_wren  in  1  1 = store, 0 = load (qualified by i_req)
- i_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_lsu_addr  in  32  byte address
- i_st_data  in  32  store data, right-aligned
- i_io_sw  in  32  switch inputs
- i_io_btn  in  4  key inputs
- o_ld_data  out  32  extended load result
- o_rsp_valid  out  1  response for the request of the previous cycle
- o_err  out  1  previous request misaligned, unmapped or illegal funct3
- o_io_out  out  32*NUM_OUT_CH  output channels, channel k at bits [32k+31:32k]

## Operation
- Regions (byte address A):
  - DMEM: A < DMEM_WORDS*4, word index A[log2(DMEM_WORDS)+1:2]
  - OUT: channel k at IO_BASE + 16*k, k < NUM_OUT_CH; read/write
  - SW: IO_BASE + 0x800, read-only
  - BTN: IO_BASE + 0x810, read-only, zero-extended
  - Everything else is unmapped.
- Alignment: H requires A[0]=0, W requires A[1:0]=00.
- Byte-lane mask:
  - B: lane A[1:0]
  - H: lanes {A[1],0} and {A[1],1}
  - W: all four lanes
  - Store data is replicated into the lanes: B = {4{d[7:0]}}, H = {2{d[15:0]}}.
- Store (i_req & i_wren): only the masked lanes of the DMEM word or OUT channel are written.
  - Suppressed, with o_err=1, if misaligned, unmapped, read-only region, or funct3 not in {000,001,010}.
  - o_ld_data = 0 for stores.
- Load (i_req & ~i_wren): lane extraction uses the registered A[1:0] and funct3.
  - B/H are sign-extended; BU/HU are zero-extended.
  - Error loads return 0 with o_err=1.
- Idle (i_req=0): o_rsp_valid=0 next cycle; o_ld_data and o_err are 0.

## Timing
- Latency is 1 cycle: a request at edge N produces o_rsp_valid, o_ld_data and o_err valid after edge N+1 (registered, synchronous RAM read).
- Throughput is one request per cycle with no stall. The block has a single port, so a load and a store never occur in the same cycle.
- Store effects:
  - DMEM and o_io_out update at the edge ending the store cycle.
  - A load of the same address in the next cycle returns the new data.
- Reset (asynchronous, on i_rst_n low):
  - o_io_out, o_ld_data, o_rsp_valid, o_err go to 0 immediately.
  - Synchronizer flops go to 0.
  - DMEM contents are not reset; they are zero-initialised at configuration.
  - A request in flight when reset asserts is dropped and produces no response.
- Reset release: the first request is accepted at the first edge with i_rst_n high.

## Configuration
- LSU_INPUT_SYNC_EN:
  - Defined: i_io_sw and i_io_btn pass through two-flop synchronizers before the read mux, so a switch change is visible to loads no earlier than 2 cycles later.
  - Undefined: inputs are read directly in the request cycle.

## Structure
- Package lsu_pkg holds:
  - funct3 enum
  - region enum {REG_DMEM, REG_OUT, REG_SW, REG_BTN, REG_NONE}
  - offsets SW_OFS=0x800, BTN_OFS=0x810, OUT_STRIDE=16
  - function computing the byte-lane mask
- Sub-module lsu_dmem: DMEM_WORDS x 32 synchronous RAM with 4-bit byte write enable and registered read.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 the next cycle -> o_rsp_valid=1, o_ld_data=0xDEADBEEF, o_err=0.
- SB 0x80 to 0x11 over that word, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
- SH 0x1234 to address 0x13 -> o_err=1, word at 0x10 unchanged; LW 0x12 -> o_err=1, o_ld_data=0.
- SW 0x3FFFF to IO_BASE+0x20 -> channel 2 = 0x0003FFFF, other channels unchanged; a store to IO_BASE+16*NUM_OUT_CH -> o_err=1, no channel change.
- i_io_sw=0xA5A5A5A5, LW IO_BASE+0x800 -> 0xA5A5A5A5 (3 cycles after the change with LSU_INPUT_SYNC_EN); SW to that address -> o_err=1.
- Set channel 0 = 0xFF, then pulse i_rst_n low mid-request -> o_io_out=0 and o_rsp_valid=0 immediately, with no response after release.
